ex_hazard_ctrl: RTL and testbench



---
 rtl/ex_hazard_if.sv | 30 +++
 rtl/ex_hazard_ctrl.sv | 103 ++++++++++
 tb/tb_ex_hazard_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ex_hazard_if.sv
// rtl/ex_hazard_if.sv - ID-stage operand fields in, stall and EX forward selects out
interface ex_hazard_if #(
  parameter int REG_W = 5
);
  logic             id_valid;
  logic [REG_W-1:0] id_rn;
  logic [REG_W-1:0] id_rm;
  logic             id_use_a;
  logic             id_use_b;
  logic [REG_W-1:0] id_rd;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             flush;
  logic             stall;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             ex_valid;

  modport master (
    output id_valid, id_rn, id_rm, id_use_a, id_use_b, id_rd,
           id_reg_write, id_mem_read, flush,
    input  stall, fwd_a_sel, fwd_b_sel, ex_valid
  );

  modport slave (
    input  id_valid, id_rn, id_rm, id_use_a, id_use_b, id_rd,
           id_reg_write, id_mem_read, flush,
    output stall, fwd_a_sel, fwd_b_sel, ex_valid
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// rtl/ex_hazard_ctrl.sv - LEGv8 EX-stage hazard/forwarding control; EX_FWD_EN enables forwarding
module ex_hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31
) (
  input  logic        clk,
  input  logic        reset,
  ex_hazard_if.slave  bus
);
  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

  logic             ex_v_q;
  logic [REG_W-1:0] ex_rd_q;
  logic             ex_rw_q;
  logic             mem_v_q;
  logic [REG_W-1:0] mem_rd_q;
  logic             mem_rw_q;

  logic ex_writer;
  logic mem_writer;
  logic a_hit_ex;
  logic b_hit_ex;
  logic a_hit_mem;
  logic b_hit_mem;
  logic stall_c;
  logic issue;

  assign ex_writer  = ex_v_q  & ex_rw_q  & (ex_rd_q  != ZR);
  assign mem_writer = mem_v_q & mem_rw_q & (mem_rd_q != ZR);

  // Hits only count against writers, so XZR never matches.
  assign a_hit_ex  = ex_writer  & bus.id_use_a & (bus.id_rn == ex_rd_q);
  assign b_hit_ex  = ex_writer  & bus.id_use_b & (bus.id_rm == ex_rd_q);
  assign a_hit_mem = mem_writer & bus.id_use_a & (bus.id_rn == mem_rd_q);
  assign b_hit_mem = mem_writer & bus.id_use_b & (bus.id_rm == mem_rd_q);

`ifdef EX_FWD_EN
  logic       ex_mr_q;
  logic [1:0] fa_q;
  logic [1:0] fb_q;
  logic [1:0] fa_next;
  logic [1:0] fb_next;

  // Only a load one instruction ahead cannot be forwarded in time.
  assign stall_c = bus.id_valid & ~bus.flush & ex_mr_q & (a_hit_ex | b_hit_ex);

  always_comb begin
    fa_next = 2'b00;
    fb_next = 2'b00;
    if (issue) begin
      if (a_hit_ex)       fa_next = 2'b01;
      else if (a_hit_mem) fa_next = 2'b10;
      if (b_hit_ex)       fb_next = 2'b01;
      else if (b_hit_mem) fb_next = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_mr_q <= 1'b0;
      fa_q    <= 2'b00;
      fb_q    <= 2'b00;
    end else begin
      ex_mr_q <= issue & bus.id_mem_read;
      fa_q    <= fa_next;
      fb_q    <= fb_next;
    end
  end

  assign bus.fwd_a_sel = fa_q;
  assign bus.fwd_b_sel = fb_q;
`else
  // Without forwarding, every RAW against EX or MEM waits for write-back.
  assign stall_c = bus.id_valid & ~bus.flush &
                   (a_hit_ex | b_hit_ex | a_hit_mem | b_hit_mem);

  assign bus.fwd_a_sel = 2'b00;
  assign bus.fwd_b_sel = 2'b00;
`endif

  assign issue = bus.id_valid & ~bus.flush & ~stall_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_v_q   <= 1'b0;
      ex_rd_q  <= '0;
      ex_rw_q  <= 1'b0;
      mem_v_q  <= 1'b0;
      mem_rd_q <= '0;
      mem_rw_q <= 1'b0;
    end else begin
      mem_v_q  <= ex_v_q;
      mem_rd_q <= ex_rd_q;
      mem_rw_q <= ex_rw_q;
      ex_v_q   <= issue;
      ex_rd_q  <= issue ? bus.id_rd : '0;
      ex_rw_q  <= issue & bus.id_reg_write;
    end
  end

  assign bus.stall    = stall_c & ~reset;
  assign bus.ex_valid = ex_v_q;
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb/tb_ex_hazard_ctrl.sv - directed bench for ex_hazard_ctrl (both EX_FWD_EN builds)
module tb_ex_hazard_ctrl;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  ex_hazard_if #(.REG_W(5)) bus ();

  ex_hazard_ctrl #(.REG_W(5), .ZERO_REG(31)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                       input logic ua, input logic ub, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic fl);
    bus.id_valid     = v;
    bus.id_rn        = rn;
    bus.id_rm        = rm;
    bus.id_use_a     = ua;
    bus.id_use_b     = ub;
    bus.id_rd        = rd;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.flush        = fl;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic add_i(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                       input logic fl);
    drive(1'b1, rn, rm, 1'b1, 1'b1, rd, 1'b1, 1'b0, fl);
  endtask

  task automatic ldur(input logic [4:0] rd, input logic [4:0] rn);
    drive(1'b1, rn, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1, 1'b0);
  endtask

  // Called just after a negedge with inputs applied; returns at the next negedge.
  task automatic step(input string tag, input logic s, input logic ev,
                      input logic [1:0] fa, input logic [1:0] fb);
    #1;
    chk({tag, ".stall"}, {1'b0, bus.stall}, {1'b0, s});
    @(posedge clk);
    #1;
    chk({tag, ".ex_valid"}, {1'b0, bus.ex_valid}, {1'b0, ev});
    chk({tag, ".fwd_a"}, bus.fwd_a_sel, fa);
    chk({tag, ".fwd_b"}, bus.fwd_b_sel, fb);
    @(negedge clk);
  endtask

  task automatic drain();
    nop(); step("drain0", 1'b0, 1'b0, 2'b00, 2'b00);
    nop(); step("drain1", 1'b0, 1'b0, 2'b00, 2'b00);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    nop();
    @(negedge clk);
    #1;
    chk("rst.stall", {1'b0, bus.stall}, 2'b00);
    chk("rst.ex_valid", {1'b0, bus.ex_valid}, 2'b00);
    chk("rst.fwd_a", bus.fwd_a_sel, 2'b00);
    chk("rst.fwd_b", bus.fwd_b_sel, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    drain();

    // ADD X1,X2,X3 ; SUB X4,X1,X1
    add_i(5'd1, 5'd2, 5'd3, 1'b0); step("d1.add", 1'b0, 1'b1, 2'b00, 2'b00);
    add_i(5'd4, 5'd1, 5'd1, 1'b0);
`ifdef EX_FWD_EN
    step("d1.sub", 1'b0, 1'b1, 2'b01, 2'b01);
`else
    step("d1.sub_s1", 1'b1, 1'b0, 2'b00, 2'b00);
    step("d1.sub_s2", 1'b1, 1'b0, 2'b00, 2'b00);
    step("d1.sub", 1'b0, 1'b1, 2'b00, 2'b00);
`endif
    drain();

    // ADD X5 ; NOP ; ORR X6,X7,X5
    add_i(5'd5, 5'd2, 5'd3, 1'b0); step("d2.add", 1'b0, 1'b1, 2'b00, 2'b00);
    nop();                         step("d2.nop", 1'b0, 1'b0, 2'b00, 2'b00);
    add_i(5'd6, 5'd7, 5'd5, 1'b0);
`ifdef EX_FWD_EN
    step("d2.orr", 1'b0, 1'b1, 2'b00, 2'b10);
`else
    step("d2.orr_s1", 1'b1, 1'b0, 2'b00, 2'b00);
    step("d2.orr", 1'b0, 1'b1, 2'b00, 2'b00);
`endif
    drain();

    // ADD X5 ; ADD X5 ; ADD X8,X5,X0 -> nearest producer wins
    add_i(5'd5, 5'd1, 5'd2, 1'b0); step("near.p1", 1'b0, 1'b1, 2'b00, 2'b00);
    add_i(5'd5, 5'd3, 5'd4, 1'b0); step("near.p2", 1'b0, 1'b1, 2'b00, 2'b00);
    add_i(5'd8, 5'd5, 5'd0, 1'b0);
`ifdef EX_FWD_EN
    step("near.use", 1'b0, 1'b1, 2'b01, 2'b00);
`else
    step("near.s1", 1'b1, 1'b0, 2'b00, 2'b00);
    step("near.s2", 1'b1, 1'b0, 2'b00, 2'b00);
    step("near.use", 1'b0, 1'b1, 2'b00, 2'b00);
`endif
    drain();

    // LDUR X9,[X2] ; ADD X1,X9,X3 -> load-use
    ldur(5'd9, 5'd2);              step("lu.ld", 1'b0, 1'b1, 2'b00, 2'b00);
    add_i(5'd1, 5'd9, 5'd3, 1'b0); step("lu.s1", 1'b1, 1'b0, 2'b00, 2'b00);
`ifdef EX_FWD_EN
    step("lu.add", 1'b0, 1'b1, 2'b10, 2'b00);
`else
    step("lu.s2", 1'b1, 1'b0, 2'b00, 2'b00);
    step("lu.add", 1'b0, 1'b1, 2'b00, 2'b00);
`endif
    drain();

    // XZR producer then XZR reader
    add_i(5'd31, 5'd1, 5'd2, 1'b0);  step("xzr.w", 1'b0, 1'b1, 2'b00, 2'b00);
    add_i(5'd3, 5'd31, 5'd31, 1'b0); step("xzr.r", 1'b0, 1'b1, 2'b00, 2'b00);
    drain();

    // LDUR X9 ; dependent ADD flushed ; ADD X10,X9,X9
    ldur(5'd9, 5'd2);              step("fl.ld", 1'b0, 1'b1, 2'b00, 2'b00);
    add_i(5'd1, 5'd9, 5'd3, 1'b1); step("fl.add", 1'b0, 1'b0, 2'b00, 2'b00);
    add_i(5'd10, 5'd9, 5'd9, 1'b0);
`ifdef EX_FWD_EN
    step("fl.both", 1'b0, 1'b1, 2'b10, 2'b10);
`else
    step("fl.s1", 1'b1, 1'b0, 2'b00, 2'b00);
    step("fl.both", 1'b0, 1'b1, 2'b00, 2'b00);
`endif
    drain();

    // Reset asserted in the middle of a load-use stall with both slots valid
    add_i(5'd20, 5'd1, 5'd2, 1'b0); step("mr.a", 1'b0, 1'b1, 2'b00, 2'b00);
    ldur(5'd9, 5'd2);               step("mr.ld", 1'b0, 1'b1, 2'b00, 2'b00);
    add_i(5'd1, 5'd9, 5'd3, 1'b0);
    #1;
    chk("mr.pre_stall", {1'b0, bus.stall}, 2'b01);
    reset = 1'b1;
    #1;
    chk("mr.stall", {1'b0, bus.stall}, 2'b00);
    chk("mr.ex_valid", {1'b0, bus.ex_valid}, 2'b00);
    chk("mr.fwd_a", bus.fwd_a_sel, 2'b00);
    chk("mr.fwd_b", bus.fwd_b_sel, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    add_i(5'd2, 5'd1, 5'd3, 1'b0); step("mr.first", 1'b0, 1'b1, 2'b00, 2'b00);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
